fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'd0, first fetch address after reset.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port address_imem  out  32  instruction-memory word address.
REQ-006 SHALL have port imem_req  out  1  high when a fetch is issued this cycle.
REQ-007 SHALL have port q_imem  in  32  imem data, valid the cycle after an issued request.
REQ-008 SHALL have port redirect  in  1  branch/jump taken; flush and refetch.
REQ-009 SHALL have port redirect_pc  in  32  new fetch address, sampled when redirect=1.
REQ-010 SHALL have port out_valid  out  1  instruction available to decode.
REQ-011 SHALL have port out_ready  in  1  decode accepts (low = stall, e.g. multdiv busy).
REQ-012 SHALL have port out_instr  out  32  instruction word at queue head.
REQ-013 SHALL have port out_pc  out  32  address of out_instr.
REQ-014 SHALL have port level  out  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-015 SHALL drive address_imem = pc_q, combinationally.
REQ-016 SHALL assert imem_req = !redirect && (level + inflight < DEPTH), where inflight is 1 if a request was issued last cycle and not dropped.
REQ-017 SHALL, on an issue, set pc_q <= pc_q + 1 (modulo 2^32; 32'hFFFFFFFF wraps to 0) and set inflight with tag pc = pc_q.
REQ-018 SHALL capture {q_imem, tag} into the queue tail in the cycle following an issue, unless redirect is high in that capture cycle.
REQ-019 SHALL complete a pop when out_valid && out_ready; pop and capture in the same cycle SHALL leave level unchanged.
REQ-020 SHALL deliver instructions strictly in fetch order, one per cycle maximum, sustaining one per cycle when out_ready stays high.
REQ-021 SHALL never overflow: credit rule REQ-016 guarantees a capture slot; level SHALL never exceed DEPTH.
REQ-022 SHALL hold out_instr/out_pc stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on redirect=1 at an edge: empty the queue (level=0), drop any inflight response, and set pc_q <= redirect_pc; redirect has priority over issue, capture and pop.
REQ-024 SHALL treat a handshake coinciding with redirect as completed by the consumer; the entry is discarded with the flush.
REQ-025 SHALL, when redirect is held high multiple cycles, load redirect_pc every cycle and issue nothing.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.

Reset
REQ-027 SHALL, while reset=1, asynchronously force pc_q=RESET_PC, level=0, inflight=0, pointers=0, all queue storage=0.
REQ-028 SHALL present out_valid=0, out_instr=0, out_pc=0, level=0, address_imem=RESET_PC during reset.
REQ-029 SHALL issue the first request (imem_req=1) in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL support macro FETCH_QUEUE_BYPASS_EN.
REQ-031 With FETCH_QUEUE_BYPASS_EN defined: when level=0 and a capture occurs, SHALL present q_imem/tag on out_instr/out_pc with out_valid=1 in the capture cycle; if out_ready=1 the word SHALL NOT be written to the queue (fetch-to-decode latency 1 cycle).
REQ-032 Without FETCH_QUEUE_BYPASS_EN: every captured word SHALL pass through the queue; out_valid rises the cycle after capture (latency 2 cycles).

Verification
REQ-033 Reset release, out_ready=1, imem returns mem[a]=a+100 -> out_pc sequence 0,1,2,3 with out_instr 100,101,102,103, one per cycle, latency per REQ-031/032.
REQ-034 out_ready=0 for 10 cycles with DEPTH=4 -> level saturates at 4, imem_req=0, out_pc held at 0; release -> pcs 0..7 delivered with no gap or duplicate.
REQ-035 redirect=1, redirect_pc=32'h40 while level=3 and request inflight -> next cycle level=0, address_imem=32'h40; first delivered out_pc=32'h40, no stale pc delivered.
REQ-036 redirect_pc=32'hFFFFFFFF, out_ready=1 -> out_pc sequence FFFFFFFF, 0, 1.
REQ-037 reset asserted mid-stream with level=2 -> same cycle out_valid=0, level=0, address_imem=RESET_PC; resumes from RESET_PC after release.
REQ-038 Pop and capture simultaneous at level=4 boundary (out_ready toggling 1/0 each cycle) -> level never exceeds 4, order preserved.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with credit-based imem issue and redirect flush
// Optional macro FETCH_QUEUE_BYPASS_EN: forward a captured word straight to decode when the queue is empty.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic [31:0]              address_imem,
   output logic                     imem_req,
   input  logic [31:0]              q_imem,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] W_DEPTH = (AW+2)'(DEPTH);

   logic [31:0]   r_pc;
   logic [31:0]   r_tag;
   logic          r_inflight;
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_level;
   logic [31:0]   r_instr_mem [DEPTH];
   logic [31:0]   r_pc_mem    [DEPTH];

   logic [AW+1:0] w_credit;
   logic          w_issue;
   logic          w_capture;
   logic          w_bypass;
   logic          w_pop;
   logic          w_write;
   logic          w_qpop;

   // An outstanding request already owns a slot, so count it against the free space.
   assign w_credit  = {1'b0, r_level} + (AW+2)'(r_inflight);
   assign w_issue   = !redirect && (w_credit < W_DEPTH);
   assign w_capture = r_inflight && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign w_bypass  = w_capture && (r_level == '0);
`else
   assign w_bypass  = 1'b0;
`endif

   assign address_imem = r_pc;
   assign imem_req     = w_issue;
   assign level        = r_level;
   assign out_valid    = (r_level != '0) || w_bypass;
   assign out_instr    = w_bypass ? q_imem : r_instr_mem[r_rptr];
   assign out_pc       = w_bypass ? r_tag  : r_pc_mem[r_rptr];

   assign w_pop   = out_valid && out_ready;
   // A bypassed word consumed this cycle never touches storage.
   assign w_write = w_capture && !(w_bypass && out_ready);
   assign w_qpop  = w_pop && !w_bypass;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_tag      <= '0;
         r_inflight <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_instr_mem[i] <= '0;
            r_pc_mem[i]    <= '0;
         end
      end else if (redirect) begin
         r_pc       <= redirect_pc;
         r_inflight <= 1'b0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
      end else begin
         if (w_issue) begin
            r_pc       <= r_pc + 32'd1;
            r_tag      <= r_pc;
            r_inflight <= 1'b1;
         end else begin
            r_inflight <= 1'b0;
         end
         if (w_write) begin
            r_instr_mem[r_wptr] <= q_imem;
            r_pc_mem[r_wptr]    <= r_tag;
            r_wptr              <= r_wptr + AW'(1);
         end
         if (w_qpop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_level <= r_level + (AW+1)'(w_write) - (AW+1)'(w_qpop);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address_imem;
   logic        imem_req;
   logic [31:0] q_imem = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;
   int lat;
   logic [31:0] log_pc[$];
   logic [31:0] log_instr[$];

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
      .clock        (clock),
      .reset        (reset),
      .address_imem (address_imem),
      .imem_req     (imem_req),
      .q_imem       (q_imem),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .level        (level)
   );

   always #5 clock = ~clock;

   // imem model: mem[a] = a + 100, one-cycle read latency
   always @(posedge clock) q_imem <= address_imem + 32'd100;

   always @(negedge clock) begin
      if (!reset && !redirect && out_valid && out_ready) begin
         log_pc.push_back(out_pc);
         log_instr.push_back(out_instr);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic clear_log();
      log_pc.delete();
      log_instr.delete();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      clear_log();
   endtask

   function automatic logic [31:0] lp(input int i);
      return (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] li(input int i);
      return (i < log_instr.size()) ? log_instr[i] : 32'hDEAD_BEEF;
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      tick(2);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_addr", address_imem, 32'd0);
      check_eq("rst_pc", out_pc, 32'd0);
      check_eq("rst_instr", out_instr, 32'd0);

      // first fetch and streaming latency
      reset = 1'b0;
      #1;
      check_eq("first_req", 32'(imem_req), 32'd1);
      lat = 0;
      while (!out_valid && lat < 6) begin
         tick();
         lat++;
      end
      check_eq("latency", 32'(lat), 32'(LAT));
      for (int k = 0; k < 4; k++) begin
         check_eq("stream_valid", 32'(out_valid), 32'd1);
         check_eq("stream_pc", out_pc, 32'(k));
         check_eq("stream_instr", out_instr, 32'(k + 100));
         tick();
      end

      // decode stall saturates the queue, then drains without gaps
      out_ready = 1'b0;
      apply_reset();
      tick(10);
      check_eq("stall_level", 32'(level), 32'd4);
      check_eq("stall_req", 32'(imem_req), 32'd0);
      check_eq("stall_pc", out_pc, 32'd0);
      check_eq("stall_instr", out_instr, 32'd100);
      out_ready = 1'b1;
      clear_log();
      tick(8);
      check_eq("drain_count", 32'(log_pc.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check_eq("drain_pc", lp(i), 32'(i));
         check_eq("drain_instr", li(i), 32'(i + 100));
      end

      // redirect with level=3 and a request in flight
      out_ready = 1'b0;
      apply_reset();
      tick(4);
      check_eq("pre_redir_level", 32'(level), 32'd3);
      check_eq("pre_redir_req", 32'(imem_req), 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      check_eq("redir_level", 32'(level), 32'd0);
      check_eq("redir_addr", address_imem, 32'h40);
      out_ready = 1'b1;
      clear_log();
      tick(6);
      check_eq("redir_pc0", lp(0), 32'h40);
      check_eq("redir_instr0", li(0), 32'hA4);
      check_eq("redir_pc1", lp(1), 32'h41);

      // pc wrap through 2^32
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect = 1'b0;
      clear_log();
      tick(6);
      check_eq("wrap_pc0", lp(0), 32'hFFFF_FFFF);
      check_eq("wrap_pc1", lp(1), 32'h0);
      check_eq("wrap_pc2", lp(2), 32'h1);
      check_eq("wrap_instr0", li(0), 32'd99);
      check_eq("wrap_instr1", li(1), 32'd100);

      // redirect held for several cycles
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect_pc = 32'h200;
      tick();
      check_eq("hold_req", 32'(imem_req), 32'd0);
      check_eq("hold_addr", address_imem, 32'h200);
      check_eq("hold_level", 32'(level), 32'd0);
      redirect = 1'b0;
      clear_log();
      tick(5);
      check_eq("hold_pc0", lp(0), 32'h200);
      check_eq("hold_pc1", lp(1), 32'h201);

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      apply_reset();
      tick(3);
      check_eq("mid_level", 32'(level), 32'd2);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_level", 32'(level), 32'd0);
      check_eq("mid_rst_addr", address_imem, 32'd0);
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      clear_log();
      tick(6);
      check_eq("mid_resume_pc0", lp(0), 32'd0);
      check_eq("mid_resume_pc1", lp(1), 32'd1);

      // pop/capture at the full boundary with toggling ready
      out_ready = 1'b0;
      apply_reset();
      tick(6);
      check_eq("tog_full", 32'(level), 32'd4);
      clear_log();
      for (int i = 0; i < 20; i++) begin
         out_ready = (i % 2 == 0);
         tick();
         check_eq("tog_level_le4", 32'(level <= 3'd4), 32'd1);
      end
      out_ready = 1'b1;
      tick(8);
      check_eq("tog_count", 32'(log_pc.size()), 32'd18);
      for (int i = 0; i < log_pc.size(); i++) begin
         check_eq("tog_order", lp(i), 32'(i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
